// File: rtl/fetch_stage_if.sv
// Fetch stage bundle: instruction-memory read port plus the fetch -> decode handoff.
// master = fetch stage side, slave = memory/decode/branch-unit side.
interface fetch_stage_if;
   logic        imem_rd;
   logic [15:0] imem_addr;
   logic [15:0] imem_data;
   logic        imem_done;
   logic        id_stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic [15:0] instr;
   logic        instr_valid;
   logic [15:0] PC;
   logic [15:0] PC_Next;
   logic        halted;
   logic        err;

   modport master (
      output imem_rd, imem_addr, instr, instr_valid, PC, PC_Next, halted, err,
      input  imem_data, imem_done, id_stall, redirect, redirect_pc
   );

   modport slave (
      input  imem_rd, imem_addr, instr, instr_valid, PC, PC_Next, halted, err,
      output imem_data, imem_done, id_stall, redirect, redirect_pc
   );
endinterface

// File: rtl/fetch_stage.sv
// Single-outstanding instruction fetch: FETCH -> WAIT -> HOLD, with redirect and HALT.
// Latency: request to instr_valid is 2 cycles minimum (memory latency 1).
// Backpressure: id_stall freezes the held instruction; no new request until it transfers.
module fetch_stage #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'h0800
) (
   input  logic          clk,
   input  logic          rst,
   fetch_stage_if.master bus
);

   typedef enum logic [1:0] {FETCH, WAIT, HOLD, HALTED} state_t;

   state_t      state;
   logic [15:0] fetch_pc;
   logic [15:0] instr_q;
   logic [15:0] pc_q;
   logic        valid_q;
   logic        halted_q;
   logic        err_q;
   logic        pend_vld;
   logic [15:0] pend_pc;

   logic [15:0] redir_tgt;
   logic        xfer;
   logic        is_halt;

   // Redirect targets are forced to halfword alignment; the low bit only feeds err.
   assign redir_tgt = bus.redirect_pc & 16'hFFFE;
   assign xfer      = valid_q & ~bus.id_stall;
   assign is_halt   = (instr_q[15:11] == 5'b00000);

   // Request is live in FETCH and WAIT; reset kills it immediately so an abandoned read is dropped.
   assign bus.imem_rd     = ~rst & ((state == FETCH) | (state == WAIT));
   assign bus.imem_addr   = fetch_pc;
   assign bus.instr       = instr_q;
   assign bus.instr_valid = valid_q;
   assign bus.PC          = pc_q;
   assign bus.PC_Next     = pc_q + 16'd2;
   assign bus.halted      = halted_q;
   assign bus.err         = err_q;

   // Fetch FSM with registered decode-side outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FETCH;
         fetch_pc <= RESET_PC;
         instr_q  <= NOP_INSTR;
         pc_q     <= RESET_PC;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         err_q    <= 1'b0;
         pend_vld <= 1'b0;
         pend_pc  <= RESET_PC;
      end else begin
         // Misaligned redirect is remembered until reset; HALTED ignores redirects entirely.
         if (bus.redirect && bus.redirect_pc[0] && state != HALTED)
            err_q <= 1'b1;

         case (state)
            FETCH: begin
               if (bus.redirect) begin
                  fetch_pc <= redir_tgt;
                  valid_q  <= 1'b0;
                  instr_q  <= NOP_INSTR;
               end else begin
                  state <= WAIT;
               end
            end

            WAIT: begin
               if (bus.imem_done) begin
                  pend_vld <= 1'b0;
                  if (bus.redirect) begin
                     // Newest redirect wins even when it lands on the completion cycle.
                     fetch_pc <= redir_tgt;
                     state    <= FETCH;
                  end else if (pend_vld) begin
                     fetch_pc <= pend_pc;
                     state    <= FETCH;
                  end else begin
                     instr_q  <= bus.imem_data;
                     pc_q     <= fetch_pc;
                     valid_q  <= 1'b1;
                     fetch_pc <= fetch_pc + 16'd2;
                     state    <= HOLD;
                  end
               end else if (bus.redirect) begin
                  // Address must stay stable until the read completes, so park the target.
                  pend_vld <= 1'b1;
                  pend_pc  <= redir_tgt;
               end
            end

            HOLD: begin
               if (bus.redirect) begin
                  // Squash overrides a same-cycle transfer, including a HALT.
                  fetch_pc <= redir_tgt;
                  valid_q  <= 1'b0;
                  instr_q  <= NOP_INSTR;
                  state    <= FETCH;
               end else if (xfer) begin
                  valid_q <= 1'b0;
                  instr_q <= NOP_INSTR;
                  if (is_halt) begin
                     halted_q <= 1'b1;
                     state    <= HALTED;
                  end else begin
                     state <= FETCH;
                  end
               end
            end

            HALTED: begin
               state <= HALTED;
            end

            default: begin
               state <= FETCH;
            end
         endcase
      end
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 Parameter: NOP_INSTR, 16'h0800, instruction presented when no valid instruction is held.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: imem_rd  output  1  instruction-memory read request; held high until imem_done.
REQ-006 Port: imem_addr  output  16  fetch address; stable while imem_rd is high.
REQ-007 Port: imem_data  input  16  returned instruction; valid only in the imem_done cycle.
REQ-008 Port: imem_done  input  1  read complete; latency is 1..N cycles after imem_rd rises.
REQ-009 Port: id_stall  input  1  decode cannot accept this cycle.
REQ-010 Port: redirect  input  1  taken branch/jump this cycle.
REQ-011 Port: redirect_pc  input  16  redirect target.
REQ-012 Port: instr  output  16  instruction to decode; NOP_INSTR when instr_valid=0.
REQ-013 Port: instr_valid  output  1  instr/PC/PC_Next hold a live instruction.
REQ-014 Port: PC  output  16  address of instr.
REQ-015 Port: PC_Next  output  16  PC+2, modulo 2^16.
REQ-016 Port: halted  output  1  HALT retired to decode; fetch stopped.
REQ-017 Port: err  output  1  sticky misaligned-redirect flag.

Function
REQ-018 States: FETCH, WAIT, HOLD, HALTED; registered state, fetch_pc and output registers.
REQ-019 FETCH: assert imem_rd with imem_addr=fetch_pc; next state WAIT.
REQ-020 WAIT: keep imem_rd=1 with the same address; on imem_done, capture imem_data and fetch_pc into instr/PC, set instr_valid, fetch_pc<=fetch_pc+2, go HOLD.
REQ-021 HOLD: transfer occurs on a cycle with instr_valid=1 and id_stall=0; on transfer, clear instr_valid and go FETCH next cycle; otherwise hold all outputs unchanged.
REQ-022 A combinational imem_done in the same cycle as the request is not allowed; minimum fetch-to-valid latency is 2 cycles.
REQ-023 HALT: on transfer of an instruction with instr[15:11]=5'b00000, go HALTED, set halted=1, stop requests; only rst exits HALTED.
REQ-024 Redirect in FETCH or HOLD: fetch_pc<=redirect_pc & 16'hFFFE; clear instr_valid (squash held instr); next state FETCH.
REQ-025 Redirect in WAIT: latch target; keep imem_rd until imem_done, discard that data, then load the latched target and go FETCH.
REQ-026 A redirect during a transfer cycle overrides the transfer: the held instr is squashed and HALT is not taken.
REQ-027 A second redirect while one is pending in WAIT replaces the latched target.
REQ-028 redirect in HALTED is ignored.
REQ-029 redirect_pc[0]=1 sets err=1 (sticky until rst); fetching continues at the aligned target.
REQ-030 fetch_pc+2 wraps 16'hFFFE -> 16'h0000 without error.
REQ-031 PC_Next is combinational PC+2.

Reset
REQ-032 While rst=1: state=FETCH, fetch_pc=RESET_PC, instr=NOP_INSTR, instr_valid=0, PC=RESET_PC, halted=0, err=0, imem_rd=0, and any pending redirect is cleared.
REQ-033 rst asserted mid-WAIT abandons the outstanding read; an imem_done arriving after reset is ignored.
REQ-034 The first request issues the cycle after rst deasserts.

Verification
REQ-035 After reset, memory latency 1, id_stall=0, words 16'h4000/16'h4100 -> imem_addr sequence 0x0000, 0x0002; instr_valid pulses show PC=0x0000 and then PC=0x0002; PC_Next=0x0002 and then 0x0004.
REQ-036 id_stall=1 for 3 cycles while HOLD with instr=16'h4000 -> instr, PC and instr_valid are stable for 3 cycles; the next request issues after stall drops.
REQ-037 Latency 4 with redirect_pc=0x0040 asserted during WAIT of 0x0002 -> the returned data is discarded, the next imem_addr is 0x0040, and no instr_valid is seen for 0x0002.
REQ-038 Transfer of 16'h0000 at PC 0x0006 -> halted=1 the next cycle, imem_rd stays 0 indefinitely, and redirect is ignored.
REQ-039 redirect_pc=0x0013 -> err=1 and stays 1, and the next imem_addr is 0x0012.
REQ-040 fetch_pc=0xFFFE -> instr at PC 0xFFFE with PC_Next=0x0000; the next imem_addr is 0x0000 and err stays 0.
